// File: rtl/core_inst_seq_pkg.sv
// Shared constants for the conv-tile instruction sequencer: tile geometry, inst bit map,
// FSM encodings and an address saturation helper.
package core_inst_seq_pkg;

  localparam int unsigned Row    = 8;
  localparam int unsigned Col    = 8;
  localparam int unsigned LenNij = 36;
  localparam int unsigned LenKij = 9;
  localparam int unsigned RstLen = 10;
  localparam logic [10:0] WBase  = 11'h400;

  // Longest phase (EXEC) sets the counter width.
  localparam int unsigned CntW  = $clog2(LenNij + Row + Col + 1);
  localparam int unsigned InstW = 34;

  localparam int unsigned InstAcc     = 33;
  localparam int unsigned InstCenP    = 32;
  localparam int unsigned InstWenP    = 31;
  localparam int unsigned InstApLsb   = 20;
  localparam int unsigned InstCenX    = 19;
  localparam int unsigned InstWenX    = 18;
  localparam int unsigned InstAxLsb   = 7;
  localparam int unsigned InstOfifoRd = 6;
  localparam int unsigned InstIfifoWr = 5;
  localparam int unsigned InstIfifoRd = 4;
  localparam int unsigned InstL0Rd    = 3;
  localparam int unsigned InstL0Wr    = 2;
  localparam int unsigned InstExecute = 1;
  localparam int unsigned InstLoad    = 0;

  // Both SRAMs deselected, no FIFO/array activity, acc low.
  localparam logic [InstW-1:0] IdleInst = {1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StCrst   = 4'd1;
  localparam logic [3:0] StWreq   = 4'd2;
  localparam logic [3:0] StWl0    = 4'd3;
  localparam logic [3:0] StWload  = 4'd4;
  localparam logic [3:0] StWdrain = 4'd5;
  localparam logic [3:0] StXl0    = 4'd6;
  localparam logic [3:0] StExec   = 4'd7;
  localparam logic [3:0] StOfrd   = 4'd8;

  function automatic logic [10:0] sat_addr(input logic [CntW-1:0] t, input int unsigned lim);
    if (32'(t) > lim) return 11'(lim);
    return 11'(t);
  endfunction

endpackage

// File: rtl/core_inst_seq_phase_cnt.sv
// Phase counter: clears on phase exit, increments on request, otherwise holds.
// Exposes its next value so registered outputs can be decoded one cycle ahead.
module core_inst_seq_phase_cnt #(
  parameter int unsigned Width = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [Width-1:0] last_i,
  output logic [Width-1:0] cnt_nxt_o,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_nxt_o = cnt_d;
  assign tc_o      = (cnt_q == last_i);

endmodule

// File: rtl/core_inst_seq.sv
// Conv-tile instruction sequencer: walks 9 kernel positions through weight load, activation
// load, execute and psum write-back, emitting a registered 34-bit core inst word.
module core_inst_seq
  import core_inst_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             w_req,
  input  logic             w_ack,
  input  logic             ofifo_valid,
  output logic [InstW-1:0] inst,
  output logic             core_reset,
  output logic [3:0]       kij,
  output logic             busy,
  output logic             done
);

  if (LenNij * LenKij > 2048) begin : g_pmem_check
    $error("psum address space exceeds 11 bits");
  end

  logic [3:0]       state_q, state_d, phase_nxt;
  logic [3:0]       kij_q, kij_d;
  logic [InstW-1:0] inst_q, inst_d;
  logic             core_reset_q, core_reset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             w_req_q, w_req_d;
  logic             fixed_len, rd_now;
  logic             cnt_clr, cnt_inc, cnt_tc;
  logic [CntW-1:0]  cnt_last, cnt_d;

  core_inst_seq_phase_cnt #(
    .Width (CntW)
  ) u_phase_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .last_i    (cnt_last),
    .cnt_nxt_o (cnt_d),
    .tc_o      (cnt_tc)
  );

  // A beat was issued this cycle only if the registered word carries ofifo_rd.
  assign rd_now = inst_q[InstOfifoRd];

  always_comb begin
    state_d   = state_q;
    kij_d     = kij_q;
    done_d    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cnt_last  = '0;
    fixed_len = 1'b0;
    phase_nxt = StIdle;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCrst;
          cnt_clr = 1'b1;
        end
      end
      StCrst:   begin fixed_len = 1'b1; phase_nxt = StWreq;   cnt_last = CntW'(RstLen - 1); end
      StWreq: begin
        if (w_ack) begin
          state_d = StWl0;
          cnt_clr = 1'b1;
        end
      end
      StWl0:    begin fixed_len = 1'b1; phase_nxt = StWload;  cnt_last = CntW'(Col); end
      StWload:  begin fixed_len = 1'b1; phase_nxt = StWdrain; cnt_last = CntW'(Col - 1); end
      StWdrain: begin fixed_len = 1'b1; phase_nxt = StXl0;    cnt_last = CntW'(Row + Col); end
      StXl0:    begin fixed_len = 1'b1; phase_nxt = StExec;   cnt_last = CntW'(LenNij); end
      StExec: begin
        fixed_len = 1'b1;
        phase_nxt = StOfrd;
        cnt_last  = CntW'(LenNij + Row + Col - 1);
      end
      StOfrd: begin
        cnt_last = CntW'(LenNij - 1);
        if (rd_now && cnt_tc) begin
          cnt_clr = 1'b1;
          if (kij_q == 4'(LenKij - 1)) begin
            state_d = StIdle;
            kij_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = StCrst;
            kij_d   = kij_q + 4'd1;
          end
        end else if (rd_now) begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (fixed_len) begin
      if (cnt_tc) begin
        state_d = phase_nxt;
        cnt_clr = 1'b1;
      end else begin
        cnt_inc = 1'b1;
      end
    end
  end

  // Outputs are decoded from the next state so they land in the register with it.
  always_comb begin
    inst_d       = IdleInst;
    core_reset_d = (state_d == StCrst);
    w_req_d      = (state_d == StWreq);
    busy_d       = (state_d != StIdle);
    case (state_d)
      StWl0: begin
        inst_d[InstIfifoWr]        = 1'b1;
        inst_d[InstCenX]           = 1'b0;
        inst_d[InstAxLsb +: 11]    = WBase + sat_addr(cnt_d, Col - 1);
      end
      StWload: begin
        inst_d[InstIfifoRd] = 1'b1;
        inst_d[InstLoad]    = 1'b1;
      end
      StWdrain: inst_d[InstLoad] = 1'b1;
      StXl0: begin
        inst_d[InstL0Wr]        = 1'b1;
        inst_d[InstCenX]        = 1'b0;
        inst_d[InstAxLsb +: 11] = sat_addr(cnt_d, LenNij - 1);
      end
      StExec: begin
        inst_d[InstL0Rd]    = 1'b1;
        inst_d[InstExecute] = 1'b1;
      end
      StOfrd: begin
        if (ofifo_valid) begin
          inst_d[InstOfifoRd]     = 1'b1;
          inst_d[InstCenP]        = 1'b0;
          inst_d[InstWenP]        = 1'b0;
          inst_d[InstApLsb +: 11] = 11'(LenNij) * 11'(kij_d) + 11'(cnt_d);
        end
      end
      default: ;
    endcase
    inst_d[InstAcc] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      kij_q        <= '0;
      inst_q       <= IdleInst;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      w_req_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      kij_q        <= kij_d;
      inst_q       <= inst_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      w_req_q      <= w_req_d;
    end
  end

  assign inst       = inst_q;
  assign core_reset = core_reset_q;
  assign kij        = kij_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign w_req      = w_req_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Scoreboard bench: tile-level expected event stream versus observed non-idle output cycles.
module tb_core_inst_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        w_ack = 1'b0;
  logic        ofifo_valid = 1'b1;
  logic        w_req, core_reset, busy, done;
  logic [33:0] inst;
  logic [3:0]  kij;

  core_inst_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .w_req       (w_req),
    .w_ack       (w_ack),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .core_reset  (core_reset),
    .kij         (kij),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];
  int  busy_cnt, exp_busy, done_seen;
  bit  mon_en = 1'b0;
  int  d_tab[9], stall_beat[9], stall_len[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] mk(input bit cenp, input bit wenp, input int ap, input bit cenx,
                                     input bit wenx, input int ax, input logic [6:0] ctl);
    logic [33:0] w;
    w        = '0;
    w[32]    = cenp;
    w[31]    = wenp;
    w[30:20] = 11'(ap);
    w[19]    = cenx;
    w[18]    = wenx;
    w[17:7]  = 11'(ax);
    w[6:0]   = ctl;
    return w;
  endfunction

  function automatic logic [39:0] ev(input bit cr, input bit wr, input int k, input logic [33:0] i);
    return {cr, wr, 4'(k), i};
  endfunction

  logic [33:0] idle_w;
  initial idle_w = mk(1, 1, 0, 1, 1, 0, 7'h00);

  // Expected tile: every cycle that shows core_reset, w_req or a non-idle word, in order.
  task automatic push_tile();
    exp_busy = 0;
    for (int k = 0; k < 9; k++) begin
      repeat (10) exp_q.push_back(ev(1, 0, k, idle_w));
      for (int w = 0; w <= d_tab[k]; w++) exp_q.push_back(ev(0, 1, k, idle_w));
      for (int t = 0; t < 9; t++)
        exp_q.push_back(ev(0, 0, k, mk(1, 1, 0, 0, 1, 'h400 + (t < 7 ? t : 7), 7'h20)));
      repeat (8)  exp_q.push_back(ev(0, 0, k, mk(1, 1, 0, 1, 1, 0, 7'h11)));
      repeat (17) exp_q.push_back(ev(0, 0, k, mk(1, 1, 0, 1, 1, 0, 7'h01)));
      for (int t = 0; t < 37; t++)
        exp_q.push_back(ev(0, 0, k, mk(1, 1, 0, 0, 1, (t < 35 ? t : 35), 7'h04)));
      repeat (52) exp_q.push_back(ev(0, 0, k, mk(1, 1, 0, 1, 1, 0, 7'h0A)));
      for (int b = 0; b < 36; b++)
        exp_q.push_back(ev(0, 0, k, mk(0, 0, 36 * k + b, 1, 1, 0, 7'h40)));
      exp_busy += 169 + d_tab[k] + 1 + stall_len[k];
    end
  endtask

  always @(negedge clk) begin
    logic [39:0] e;
    if (mon_en) begin
      if (busy) busy_cnt++;
      if (core_reset || w_req || inst !== idle_w) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %0h expected none", {core_reset, w_req, kij, inst});
        end else begin
          e = exp_q.pop_front();
          chk("event", {core_reset, w_req, kij, inst}, e);
        end
      end
      if (done) begin
        done_seen++;
        chk("done_queue_left", exp_q.size(), 0);
        chk("done_cycles", busy_cnt, exp_busy);
        chk("done_kij", kij, 0);
        chk("done_busy", busy, 0);
      end
    end
  end

  task automatic gen_tab();
    for (int k = 0; k < 9; k++) begin
      d_tab[k] = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) begin
        stall_len[k]  = $urandom_range(1, 3);
        stall_beat[k] = $urandom_range(0, 34);
      end else begin
        stall_len[k]  = 0;
        stall_beat[k] = 0;
      end
    end
  endtask

  task automatic run_tile(input bit noise, input bit abort);
    int  wcnt, stall_rem, cyc, beat;
    bit  fin;
    exp_q.delete();
    push_tile();
    busy_cnt  = 0;
    done_seen = 0;
    mon_en    = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    wcnt = 0; stall_rem = 0; cyc = 0; fin = 1'b0;
    while (!fin) begin
      w_ack       = 1'b0;
      start       = 1'b0;
      ofifo_valid = 1'b1;
      if (w_req) begin
        if (wcnt == d_tab[kij]) w_ack = 1'b1;
        wcnt++;
      end else begin
        wcnt = 0;
        if (noise && $urandom_range(0, 3) == 0) w_ack = 1'b1;
      end
      if (noise && busy && $urandom_range(0, 3) == 0) start = 1'b1;
      beat = int'(inst[30:20]) - 36 * int'(kij);
      if (stall_rem > 0) begin
        ofifo_valid = 1'b0;
        stall_rem--;
      end else if (inst[6] && stall_len[kij] != 0 && beat == stall_beat[kij]) begin
        ofifo_valid = 1'b0;
        stall_rem   = stall_len[kij] - 1;
      end
      if (abort && kij == 4 && inst[1]) begin
        reset  = 1'b0;
        mon_en = 1'b0;
        start  = 1'b0;
        w_ack  = 1'b0;
        @(negedge clk);
        chk("abort_inst", inst, idle_w);
        chk("abort_kij", kij, 0);
        chk("abort_core_reset", core_reset, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_no_done_seen", done_seen, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        fin = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
        if (done) fin = 1'b1;
        if (cyc > 3000) begin
          checks++;
          errors++;
          $display("FAIL tile_timeout: got no done after %0d cycles expected %0d", cyc, exp_busy);
          fin = 1'b1;
        end
      end
    end
    start = 1'b0; w_ack = 1'b0; ofifo_valid = 1'b1;
    if (!abort) begin
      @(negedge clk);
      chk("done_pulses", done_seen, 1);
      chk("done_one_cycle", done, 0);
    end
    mon_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_inst", inst, idle_w);
      chk("rst_core_reset", core_reset, 1);
    end
    chk("rst_kij", kij, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wreq", w_req, 0);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("rel_core_reset", core_reset, 0);
    chk("rel_busy", busy, 0);
    chk("rel_inst", inst, idle_w);

    gen_tab();
    d_tab[0]      = 3;
    stall_len[2]  = 4;
    stall_beat[2] = 9;
    run_tile(1'b0, 1'b0);
    run_tile(1'b1, 1'b0);
    gen_tab();
    run_tile(1'b0, 1'b1);
    gen_tab();
    run_tile(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
